// File: rtl/insn_fetch_queue.sv
// Instruction prefetch queue: drives sequential fetch addresses and buffers {pc, insn} pairs for decode.
// Optional same-cycle bypass of an empty queue is enabled by defining PFQ_BYPASS_EN.
module insn_fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       imem_valid,
   input  logic                       redirect,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [PC_W-1:0]            deq_pc,
   output logic [31:0]                deq_insn,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PC_W-1:0] pc_mem_q   [DEPTH];
   logic [31:0]     insn_mem_q [DEPTH];

   logic empty, bypass_hit, bypass_take, pop, q_pop, push, advance;

   assign empty = (count_q == '0);

`ifdef PFQ_BYPASS_EN
   assign bypass_hit = empty && imem_valid && !redirect;
`else
   assign bypass_hit = 1'b0;
`endif

   // A bypassed word that decode takes immediately never occupies a slot.
   assign bypass_take = bypass_hit && deq_ready;
   assign deq_valid   = (!empty || bypass_hit) && !redirect;
   assign pop         = deq_valid && deq_ready;
   assign q_pop       = pop && !empty;
   assign push        = imem_valid && !redirect && ((count_q < FULL) || pop) && !bypass_take;
   assign advance     = push || bypass_take;

   assign imem_addr = fetch_pc_q;
   assign count     = count_q;

   always_comb begin
      deq_pc   = '0;
      deq_insn = '0;
      if (deq_valid) begin
         if (!empty) begin
            deq_pc   = pc_mem_q[rd_ptr_q];
            deq_insn = insn_mem_q[rd_ptr_q];
         end else begin
            deq_pc   = fetch_pc_q;
            deq_insn = imem_data;
         end
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push)    wr_ptr_d   = wr_ptr_q + AW'(1);
         if (q_pop)   rd_ptr_d   = rd_ptr_q + AW'(1);
         if (advance) fetch_pc_d = fetch_pc_q + PC_W'(4);
         case ({push, q_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage is intentionally left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         insn_mem_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule
